rcb_wr_sched: RTL and testbench

//  Schedules Host Protocol Block writes into the four strategy RCBs (symbol, price, volume, order).

---
 rtl/rcb_wr_sched.sv | 131 +++++++++++++
 tb/tb_rcb_wr_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcb_wr_sched.sv
// rcb_wr_sched: in-order host write scheduler for the four strategy RCBs.
// SEF reads always win the port; a head write blocked too long raises feed_hold.
module rcb_wr_sched #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_STALL  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        host_valid,
  output logic                        host_ready,
  input  logic [1:0]                  host_tbl,
  input  logic [ADDR_W-1:0]           host_addr,
  input  logic [DATA_W-1:0]           host_data,
  input  logic                        sef_rd_srcb,
  input  logic                        sef_rd_prcb,
  input  logic                        sef_rd_vrcb,
  input  logic                        sef_rd_orcb,
  output logic [3:0]                  wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic                        feed_hold,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(MAX_STALL + 1);
  localparam logic [PW:0]   FULL_LVL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [SW-1:0] STALL_ONE = SW'(1);
  localparam logic [SW-1:0] STALL_LIM = SW'(MAX_STALL - 1);
  localparam logic [SW-1:0] STALL_TOP = SW'(MAX_STALL);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    HOLD
  } state_e;

  logic [1:0]        tbl_q  [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  state_e        state_q;
  logic [SW-1:0] stall_q;
  logic          hold_q;

  logic       empty, full, conf, push, pop;
  logic [3:0] rd_vec;
  logic [1:0] head_tbl;

  assign rd_vec   = {sef_rd_orcb, sef_rd_vrcb, sef_rd_prcb, sef_rd_srcb};
  assign head_tbl = tbl_q[rd_ptr_q];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_LVL);
  assign conf     = rd_vec[head_tbl];
  assign pop      = !empty && !conf;
  assign push     = host_valid && !full;

  assign host_ready = !full;
  assign wr_addr    = addr_q[rd_ptr_q];
  assign wr_data    = data_q[rd_ptr_q];
  assign feed_hold  = hold_q;
  assign fifo_level = cnt_q;

  always_comb begin
    wr_en = '0;
    if (pop) wr_en[head_tbl] = 1'b1;
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    cnt_d    = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      tbl_q[wr_ptr_q]  <= host_tbl;
      addr_q[wr_ptr_q] <= host_addr;
      data_q[wr_ptr_q] <= host_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // stall_q saturates at MAX_STALL so a parked head never wraps back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      stall_q <= '0;
      hold_q  <= 1'b0;
    end else if (pop) begin
      stall_q <= '0;
      hold_q  <= 1'b0;
      state_q <= (cnt_d == '0) ? IDLE : PEND;
    end else if (!empty) begin
      if (stall_q != STALL_TOP) stall_q <= stall_q + STALL_ONE;
      if (state_q == HOLD || stall_q >= STALL_LIM) begin
        state_q <= HOLD;
        hold_q  <= 1'b1;
      end else begin
        state_q <= PEND;
      end
    end else begin
      state_q <= IDLE;
    end
  end

endmodule

// File: tb/tb_rcb_wr_sched.sv
// tb_rcb_wr_sched: directed vectors plus a queue-based reference model
// checked on every falling edge, with literal pins on key cycles.
module tb_rcb_wr_sched;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int MAXS   = 16;

  logic              clk;
  logic              reset;
  logic              host_valid;
  logic              host_ready;
  logic [1:0]        host_tbl;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic [3:0]        rd;
  logic [3:0]        wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              feed_hold;
  logic [2:0]        fifo_level;

  int checks = 0;
  int errors = 0;

  rcb_wr_sched #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .FIFO_DEPTH(DEPTH), .MAX_STALL(MAXS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .host_valid(host_valid),
    .host_ready(host_ready),
    .host_tbl(host_tbl),
    .host_addr(host_addr),
    .host_data(host_data),
    .sef_rd_srcb(rd[0]),
    .sef_rd_prcb(rd[1]),
    .sef_rd_vrcb(rd[2]),
    .sef_rd_orcb(rd[3]),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .feed_hold(feed_hold),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending writes in order plus blocked-cycle count of head.
  typedef struct {
    logic [1:0]        tbl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_stall = 0;
  bit   m_hold  = 0;

  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      m_stall = 0;
      m_hold  = 0;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_hold", feed_hold, 0);
    end else begin
      bit   rdy, blk, iss;
      logic [3:0] exp_en;
      ent_t e;
      rdy    = mq.size() < DEPTH;
      blk    = mq.size() > 0 && rd[mq[0].tbl];
      iss    = mq.size() > 0 && !blk;
      exp_en = '0;
      if (iss) exp_en = 4'b0001 << mq[0].tbl;
      chk("m_ready", host_ready, rdy);
      chk("m_wr_en", wr_en, exp_en);
      chk("m_level", fifo_level, mq.size());
      chk("m_hold", feed_hold, m_hold);
      if (iss) begin
        chk("m_addr", wr_addr, mq[0].addr);
        chk("m_data", wr_data, mq[0].data);
        void'(mq.pop_front());
        m_stall = 0;
        m_hold  = 0;
      end else if (blk) begin
        if (m_stall < MAXS) m_stall++;
        if (m_stall >= MAXS) m_hold = 1;
      end
      if (host_valid && rdy) begin
        e.tbl  = host_tbl;
        e.addr = host_addr;
        e.data = host_data;
        mq.push_back(e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] t,
                       input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    host_valid = v;
    host_tbl   = t;
    host_addr  = a;
    host_data  = d;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && fifo_level != 0; k++) cyc();
    chk("drain_level", fifo_level, 0);
  endtask

  initial begin
    reset = 1'b1;
    rd    = 4'b0000;
    drive(1'b0, 2'd0, '0, '0);
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    at_neg();
    chk("idle_ready", host_ready, 1);
    cyc();

    // Single price write goes out the cycle after accept.
    drive(1'b1, 2'd1, 10'h005, 64'hA5);
    cyc();
    drive(1'b0, 2'd0, '0, '0);
    at_neg();
    chk("t1_wr_en", wr_en, 4'b0010);
    chk("t1_addr", wr_addr, 10'h005);
    chk("t1_data", wr_data, 64'hA5);
    cyc();
    at_neg();
    chk("t1_level", fifo_level, 0);
    chk("t1_idle", wr_en, 0);
    cyc();

    // Fill behind a volume read; full FIFO rejects even while popping.
    rd = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd2, 10'h010 + 10'(i), 64'(i + 1));
      cyc();
    end
    drive(1'b1, 2'd2, 10'h014, 64'h5);
    at_neg();
    chk("t2_ready", host_ready, 0);
    chk("t2_no_wr", wr_en, 0);
    chk("t2_level4", fifo_level, 4);
    cyc();
    rd = 4'b0000;
    at_neg();
    chk("t2_pop_en", wr_en, 4'b0100);
    chk("t2_pop_addr", wr_addr, 10'h010);
    chk("t2_full_rdy", host_ready, 0);
    cyc();
    at_neg();
    chk("t2_level3", fifo_level, 3);
    chk("t2_ready1", host_ready, 1);
    chk("t2_addr11", wr_addr, 10'h011);
    cyc();
    drive(1'b0, 2'd0, '0, '0);
    at_neg();
    chk("t2_pushpop", fifo_level, 3);
    chk("t2_addr12", wr_addr, 10'h012);
    drain();

    // Symbol write parked behind 16 blocked cycles raises feed_hold.
    rd = 4'b0001;
    drive(1'b1, 2'd0, 10'h020, 64'hDEAD_BEEF);
    cyc();
    drive(1'b0, 2'd0, '0, '0);
    for (int k = 1; k <= MAXS; k++) begin
      at_neg();
      chk("t3_hold_lo", feed_hold, 0);
      cyc();
    end
    at_neg();
    chk("t3_hold_hi", feed_hold, 1);
    cyc();
    rd = 4'b0000;
    at_neg();
    chk("t3_wr_en", wr_en, 4'b0001);
    chk("t3_hold_wr", feed_hold, 1);
    cyc();
    at_neg();
    chk("t3_hold_clr", feed_hold, 0);
    chk("t3_level", fifo_level, 0);
    cyc();

    // Order write passes a price read; queued price write waits in order.
    rd = 4'b0010;
    drive(1'b1, 2'd3, 10'h030, 64'h30);
    cyc();
    drive(1'b1, 2'd1, 10'h031, 64'h31);
    at_neg();
    chk("t4_order", wr_en, 4'b1000);
    chk("t4_oaddr", wr_addr, 10'h030);
    cyc();
    drive(1'b0, 2'd0, '0, '0);
    at_neg();
    chk("t4_wait", wr_en, 0);
    chk("t4_level", fifo_level, 1);
    cyc();
    rd = 4'b0000;
    at_neg();
    chk("t4_price", wr_en, 4'b0010);
    chk("t4_paddr", wr_addr, 10'h031);
    cyc();
    drain();

    // Reset while in HOLD with three parked entries.
    rd = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 10'h040 + 10'(i), 64'(i));
      cyc();
    end
    drive(1'b0, 2'd0, '0, '0);
    for (int k = 0; k < 30 && feed_hold !== 1'b1; k++) cyc();
    chk("t5_hold", feed_hold, 1);
    chk("t5_level", fifo_level, 3);
    reset = 1'b1;
    #1;
    chk("t5_async_hold", feed_hold, 0);
    chk("t5_async_lvl", fifo_level, 0);
    cyc();
    reset = 1'b0;
    rd    = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("t5_no_wr", wr_en, 0);
      cyc();
    end

    // Mixed traffic, with a stretch where every RCB is being read.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            10'($urandom), {$urandom, $urandom});
      if (i >= 100 && i < 125) rd = 4'hF;
      else rd = 4'($urandom_range(0, 15));
      cyc();
    end
    drive(1'b0, 2'd0, '0, '0);
    rd = 4'b0000;
    drain();
    at_neg();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
